// File: rtl/hacd_pkg.sv
// rtl/hacd_pkg.sv - shared types and constants for the HACD read scheduler
package hacd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } sched_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         PAGE_BYTES     = 4096;

endpackage

// File: rtl/hawk_burst_calc.sv
// rtl/hawk_burst_calc.sv - beats for the next burst: min(remaining, MAX_BURST, beats left in 4KB page)
module hawk_burst_calc
    import hacd_pkg::*;
#(
    parameter int NBEATS_WIDTH = 12,
    parameter int MAX_BURST    = 16,
    parameter int BB           = 64,
    parameter int BW           = $clog2(MAX_BURST) + 1
)(
    input  logic [11:0]             i_page_off,
    input  logic [NBEATS_WIDTH-1:0] i_rem,
    output logic [BW-1:0]           o_b
);

    localparam int BB_LOG = $clog2(BB);

    logic [12:0] w_page_beats;
    logic [12:0] w_lim;

    // i_page_off is beat aligned, so the page remainder divides exactly
    assign w_page_beats = (13'(PAGE_BYTES) - {1'b0, i_page_off}) >> BB_LOG;
    assign w_lim        = (w_page_beats < 13'(MAX_BURST)) ? w_page_beats : 13'(MAX_BURST);
    assign o_b          = (32'(i_rem) < 32'(w_lim)) ? BW'(i_rem) : BW'(w_lim);

endmodule

// File: rtl/hawk_rd_sched.sv
// rtl/hawk_rd_sched.sv - round-robin read scheduler splitting requester regions into 4KB-safe AXI bursts
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif

module hawk_rd_sched
    import hacd_pkg::*;
#(
    parameter int ADDR_WIDTH   = `HACD_AXI4_ADDR_WIDTH,
    parameter int DATA_WIDTH   = `HACD_AXI4_DATA_WIDTH,
    parameter int ID_WIDTH     = `HACD_AXI4_ID_WIDTH,
    parameter int MAX_BURST    = 16,
    parameter int NBEATS_WIDTH = 12
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr0,
    input  logic [ADDR_WIDTH-1:0]   req_addr1,
    input  logic [NBEATS_WIDTH-1:0] req_nbeats0,
    input  logic [NBEATS_WIDTH-1:0] req_nbeats1,
    output logic [1:0]              done,
    output logic                    err,
    output logic                    busy,
    input  logic                    rdfifo_empty,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic                    r_fire,
    input  logic [1:0]              r_resp,
    input  logic                    r_last
);

    localparam int BB     = DATA_WIDTH / 8;
    localparam int BB_LOG = $clog2(BB);
    localparam int BW     = $clog2(MAX_BURST) + 1;
    localparam int OW     = NBEATS_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BB - 1);

    sched_state_e            r_state, w_state_nx;
    logic                    r_g, w_g_nx;
    logic                    r_rr_last, w_rr_last_nx;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nx;
    logic [NBEATS_WIDTH-1:0] r_rem, w_rem_nx;
    logic [OW-1:0]           r_outst, w_outst_nx;
    logic                    r_err_acc, w_err_acc_nx;
    logic [7:0]              r_arlen, w_arlen_nx;
    logic                    r_arvalid, w_arvalid_nx;
    logic [1:0]              r_req_ready, w_req_ready_nx;
    logic [1:0]              r_done, w_done_nx;
    logic                    r_err, w_err_nx;
    logic                    r_busy, w_busy_nx;

    logic [BW-1:0]           w_calc_b;
    logic [OW-1:0]           w_hs_b;
    logic                    w_ar_hs;
    logic                    w_count;
    logic                    w_grant;
    logic                    w_gsel;
    logic [ADDR_WIDTH-1:0]   w_addr_sel;
    logic [NBEATS_WIDTH-1:0] w_nbeats_sel;

    hawk_burst_calc #(
        .NBEATS_WIDTH (NBEATS_WIDTH),
        .MAX_BURST    (MAX_BURST),
        .BB           (BB),
        .BW           (BW)
    ) u_burst_calc (
        .i_page_off (r_addr[11:0]),
        .i_rem      (r_rem),
        .o_b        (w_calc_b)
    );

    // Round-robin: on contention the requester that did not win last time goes next
    assign w_gsel       = (&req_valid) ? ~r_rr_last : req_valid[1];
    assign w_grant      = (r_state == ST_IDLE) && (|req_valid) && rdfifo_empty && (r_outst == '0);
    assign w_addr_sel   = (w_gsel ? req_addr1 : req_addr0) & ALIGN_MASK;
    assign w_nbeats_sel = w_gsel ? req_nbeats1 : req_nbeats0;

    assign w_ar_hs = r_arvalid && m_arready;
    assign w_hs_b  = OW'(r_arlen) + OW'(1);
    assign w_count = r_fire && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) && (r_outst != '0);

    always_comb begin
        w_state_nx     = r_state;
        w_g_nx         = r_g;
        w_rr_last_nx   = r_rr_last;
        w_addr_nx      = r_addr;
        w_rem_nx       = r_rem;
        w_err_acc_nx   = r_err_acc;
        w_arlen_nx     = r_arlen;
        w_arvalid_nx   = r_arvalid;
        w_req_ready_nx = 2'b00;
        w_done_nx      = 2'b00;
        w_err_nx       = 1'b0;
        w_outst_nx     = r_outst + (w_ar_hs ? w_hs_b : '0) - (w_count ? OW'(1) : '0);

        if (w_count && (r_resp != AXI_RESP_OKAY)) begin
            w_err_acc_nx = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_req_ready_nx[w_gsel] = 1'b1;
                    w_g_nx                 = w_gsel;
                    w_rr_last_nx           = w_gsel;
                    w_addr_nx              = w_addr_sel;
                    w_rem_nx               = w_nbeats_sel;
                    w_err_acc_nx           = 1'b0;
                    w_state_nx             = (w_nbeats_sel == '0) ? ST_FIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A handshake drops arvalid, giving the one idle cycle before the next burst
                if (w_ar_hs) begin
                    w_arvalid_nx = 1'b0;
                    w_addr_nx    = r_addr + (ADDR_WIDTH'(w_hs_b) << BB_LOG);
                    w_rem_nx     = r_rem - NBEATS_WIDTH'(w_hs_b);
                    if (w_rem_nx == '0) begin
                        w_state_nx = ST_DRAIN;
                    end
                end else if (!r_arvalid) begin
                    w_arvalid_nx = 1'b1;
                    w_arlen_nx   = 8'(w_calc_b) - 8'd1;
                end
            end
            ST_DRAIN: begin
                if (r_outst == '0) begin
                    w_state_nx = ST_FIN;
                end
            end
            ST_FIN: begin
                w_done_nx[r_g] = 1'b1;
                w_err_nx       = r_err_acc;
                w_state_nx     = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase

        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_g         <= 1'b0;
            r_rr_last   <= 1'b1;
            r_addr      <= '0;
            r_rem       <= '0;
            r_outst     <= '0;
            r_err_acc   <= 1'b0;
            r_arlen     <= '0;
            r_arvalid   <= 1'b0;
            r_req_ready <= 2'b00;
            r_done      <= 2'b00;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_g         <= w_g_nx;
            r_rr_last   <= w_rr_last_nx;
            r_addr      <= w_addr_nx;
            r_rem       <= w_rem_nx;
            r_outst     <= w_outst_nx;
            r_err_acc   <= w_err_acc_nx;
            r_arlen     <= w_arlen_nx;
            r_arvalid   <= w_arvalid_nx;
            r_req_ready <= w_req_ready_nx;
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
            r_busy      <= w_busy_nx;
        end
    end

    assign req_ready = r_req_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;
    assign m_arid    = ID_WIDTH'(r_g);
    assign m_araddr  = r_addr;
    assign m_arlen   = r_arlen;
    assign m_arsize  = 3'(BB_LOG);
    assign m_arburst = AXI_BURST_INCR;
    assign m_arvalid = r_arvalid;

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (r_fire && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN))) |-> (r_outst != '0))
        else $error("hawk_rd_sched: R beat with nothing outstanding (rlast=%0b)", r_last);

endmodule

// File: tb/tb_hawk_rd_sched.sv
// tb/tb_hawk_rd_sched.sv - scoreboard bench for hawk_rd_sched with randomized traffic
module tb_hawk_rd_sched;
    import hacd_pkg::*;

    localparam int AW = 32;
    localparam int DW = 512;
    localparam int IW = 4;
    localparam int MB = 16;
    localparam int NW = 12;
    localparam int BB = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          v0 = 1'b0, v1 = 1'b0;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready, done;
    logic [AW-1:0] req_addr0 = '0, req_addr1 = '0;
    logic [NW-1:0] req_nbeats0 = '0, req_nbeats1 = '0;
    logic          err, busy, rdfifo_empty;
    logic [IW-1:0] m_arid;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid, m_arready;
    logic          r_fire, r_last;
    logic [1:0]    r_resp;

    assign req_valid = {v1, v0};

    hawk_rd_sched #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB), .NBEATS_WIDTH(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_nbeats0(req_nbeats0), .req_nbeats1(req_nbeats1),
        .done(done), .err(err), .busy(busy), .rdfifo_empty(rdfifo_empty),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .r_fire(r_fire), .r_resp(r_resp), .r_last(r_last)
    );

    typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; logic [IW-1:0] id; } ar_t;
    typedef struct packed { logic port; logic err; } done_t;
    typedef struct { int nbeats; int err_idx; } plan_t;

    ar_t   exp_ar[$];
    done_t exp_done[$];
    plan_t plan_q[$];
    int    exp_grant[$];

    int total = 0, bad = 0;
    int owed = 0, beat_idx = 0, ready_seen = 0, ar_seen = 0;
    bit r_stall = 1'b0, ar_rand = 1'b0, held = 1'b0;
    logic [AW+8+IW-1:0] held_v;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: split region into bursts by plain arithmetic on page/beat limits
    function automatic void expect_req(int port, logic [AW-1:0] addr, int nb, int err_idx);
        longint a;
        int rem, page, b;
        a   = longint'(addr) & ~longint'(BB - 1);
        rem = nb;
        while (rem > 0) begin
            page = (4096 - int'(a % 4096)) / BB;
            b    = rem;
            if (b > MB)   b = MB;
            if (b > page) b = page;
            exp_ar.push_back('{addr: AW'(a), len: 8'(b - 1), id: IW'(port)});
            a   = a + b * BB;
            rem = rem - b;
        end
        exp_done.push_back('{port: port[0], err: (err_idx >= 0 && err_idx < nb)});
        if (nb > 0) plan_q.push_back('{nbeats: nb, err_idx: err_idx});
        exp_grant.push_back(port);
    endfunction

    task automatic drive(int p, logic [AW-1:0] a, int nb);
        bit got = 1'b0;
        if (p == 0) begin req_addr0 = a; req_nbeats0 = NW'(nb); v0 = 1'b1; end
        else        begin req_addr1 = a; req_nbeats1 = NW'(nb); v1 = 1'b1; end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin got = 1'b1; break; end
        end
        check("req_accepted", 64'(got), 64'd1);
        @(posedge clk); #1;
        if (p == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_done.size() == 0 && exp_ar.size() == 0 && !busy) begin ok = 1'b1; break; end
        end
        check("idle_reached", 64'(ok), 64'd1);
    endtask

    task automatic wait_ar(int target);
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ar_seen >= target) begin ok = 1'b1; break; end
        end
        check("ar_count_reached", 64'(ok), 64'd1);
    endtask

    // Monitor: AR, grant and done outputs checked against the scoreboard queues
    initial begin
        ar_t   t;
        done_t d;
        int    g;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held && !m_arvalid) check("ar_dropped_before_ready", 64'd0, 64'd1);
                if (m_arvalid) begin
                    if (held) check("ar_stable", 64'({m_araddr, m_arlen, m_arid}), 64'(held_v));
                    if (m_arready) begin
                        held = 1'b0;
                        ar_seen++;
                        owed += int'(m_arlen) + 1;
                        if (exp_ar.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
                        else begin
                            t = exp_ar.pop_front();
                            check("ar_addr",  64'(m_araddr),  64'(t.addr));
                            check("ar_len",   64'(m_arlen),   64'(t.len));
                            check("ar_id",    64'(m_arid),    64'(t.id));
                            check("ar_size",  64'(m_arsize),  64'd6);
                            check("ar_burst", 64'(m_arburst), 64'd1);
                        end
                    end else begin
                        held   = 1'b1;
                        held_v = {m_araddr, m_arlen, m_arid};
                    end
                end else held = 1'b0;
                if (req_ready != 2'b00) begin
                    ready_seen++;
                    if (exp_grant.size() == 0) check("grant_unexpected", 64'(req_ready), 64'd0);
                    else begin
                        g = exp_grant.pop_front();
                        check("grant_port", 64'(req_ready), 64'(1 << g));
                    end
                end
                if (done != 2'b00) begin
                    if (exp_done.size() == 0) check("done_unexpected", 64'(done), 64'd0);
                    else begin
                        d = exp_done.pop_front();
                        check("done_port", 64'(done), 64'(1 << d.port));
                        check("done_err",  64'(err),  64'(d.err));
                    end
                end
            end
        end
    end

    // R responder: returns owed beats in transaction order, injecting planned errors
    initial begin
        r_fire = 1'b0; r_resp = 2'b00; r_last = 1'b0;
        forever begin
            @(posedge clk); #1;
            r_fire = 1'b0; r_resp = 2'b00; r_last = 1'b0;
            if (rst_n && !r_stall && owed > 0 && plan_q.size() > 0 && ($urandom % 4) != 0) begin
                r_fire = 1'b1;
                r_resp = (beat_idx == plan_q[0].err_idx) ? 2'b10 : 2'b00;
                r_last = (owed == 1);
                owed--;
                beat_idx++;
                if (beat_idx == plan_q[0].nbeats) begin
                    void'(plan_q.pop_front());
                    beat_idx = 0;
                end
            end
        end
    end

    initial begin
        m_arready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_arready = ar_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, first, p, nb, e;
        logic [AW-1:0] fa[2][2];
        int fn[2][2];
        logic [AW-1:0] ra;

        rst_n = 1'b0; rdfifo_empty = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_arvalid", 64'(m_arvalid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        expect_req(0, 32'h1000, 4, -1); drive(0, 32'h1000, 4); wait_idle();
        expect_req(1, 32'h0FC0, 4, -1); drive(1, 32'h0FC0, 4); wait_idle();

        r_stall = 1'b1;
        base = ar_seen;
        expect_req(0, 32'h0, 40, -1); drive(0, 32'h0, 40);
        wait_ar(base + 3);
        repeat (5) @(negedge clk);
        check("stalled_busy", 64'(busy), 64'd1);
        check("stalled_no_done", 64'(done), 64'd0);
        r_stall = 1'b0;
        wait_idle();

        expect_req(1, 32'h2000, 4, 1); drive(1, 32'h2000, 4); wait_idle();

        base = ar_seen;
        expect_req(0, 32'h3000, 0, -1); drive(0, 32'h3000, 0); wait_idle();
        check("zero_len_no_ar", 64'(ar_seen - base), 64'd0);

        rdfifo_empty = 1'b0;
        base = ready_seen;
        expect_req(1, 32'h4000, 2, -1);
        fork
            drive(1, 32'h4000, 2);
            begin
                repeat (10) @(negedge clk);
                check("no_grant_fifo_busy", 64'(ready_seen - base), 64'd0);
                @(posedge clk); #1;
                rdfifo_empty = 1'b1;
            end
        join
        wait_idle();

        ar_rand = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int q = 0; q < 2; q++) begin
                fa[q][k] = $urandom;
                fn[q][k] = $urandom_range(1, 40);
            end
        end
        first = 0;
        for (int i = 0; i < 4; i++) begin
            p = (first + i) % 2;
            expect_req(p, fa[p][i / 2], fn[p][i / 2], -1);
        end
        fork
            begin drive(0, fa[0][0], fn[0][0]); drive(0, fa[0][1], fn[0][1]); end
            begin drive(1, fa[1][0], fn[1][0]); drive(1, fa[1][1], fn[1][1]); end
        join
        wait_idle();

        for (int i = 0; i < 20; i++) begin
            p  = int'($urandom % 2);
            ra = $urandom;
            if ((i % 3) == 0) ra[11:0] = 12'hF00 | 12'($urandom % 256);
            nb = ((i % 7) == 3) ? 0 : $urandom_range(1, 70);
            e  = (nb > 0 && ($urandom % 3) == 0) ? int'($urandom % nb) : -1;
            expect_req(p, ra, nb, e);
            drive(p, ra, nb);
            wait_idle();
        end

        ar_rand = 1'b0;
        r_stall = 1'b1;
        base = ar_seen;
        expect_req(0, 32'h5000, 8, -1); drive(0, 32'h5000, 8);
        wait_ar(base + 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("drain_rst_req_ready", 64'(req_ready), 64'd0);
        check("drain_rst_done", 64'(done), 64'd0);
        check("drain_rst_err", 64'(err), 64'd0);
        check("drain_rst_busy", 64'(busy), 64'd0);
        check("drain_rst_arvalid", 64'(m_arvalid), 64'd0);
        exp_ar.delete(); exp_done.delete(); plan_q.delete(); exp_grant.delete();
        owed = 0; beat_idx = 0; held = 1'b0; r_stall = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;

        expect_req(0, 32'h6000, 3, -1);
        expect_req(1, 32'h7FC0, 5, 4);
        fork
            drive(0, 32'h6000, 3);
            drive(1, 32'h7FC0, 5);
        join
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
